// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the pipeline inter-stage buffers.
//   NOP_INSTR  : instruction word shown by an invalid (bubble) head
//   PC_RST_DEF : default pc loaded on reset and on flush
//   state_e    : buffer occupancy state (EMPTY / FULL / SKID)
package cpu_pipe_pkg;

   localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
   localparam logic [31:0] PC_RST_DEF = 32'h0000_3000;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } state_e;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter used for pipeline performance statistics.
//   clk   : clock, rising edge
//   clear : synchronous clear (highest priority)
//   inc   : add one this cycle unless already at all-ones
//   cnt   : current count
module pipe_sat_cnt #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage register for the 5-stage pipeline (F/D, D/E, E/M, M/W).
// Holds {instr, pc, data} with a valid/ready handshake, an optional skid
// slot so in_ready can be registered, flush-to-bubble, and saturating
// stall/bubble counters.
//   clk, reset          : clock; synchronous active-high reset
//   flush               : squash all held entries at the next edge
//   in_valid/in_ready   : upstream handshake
//   in_instr/pc/data    : incoming entry
//   out_valid/out_ready : downstream handshake (out_ready=0 stalls)
//   out_instr/pc/data   : head entry; instr/data read as zero when invalid
//   stall_cnt           : cycles with out_valid & !out_ready
//   bubble_cnt          : cycles with !out_valid & out_ready
module pipe_stage_buf import cpu_pipe_pkg::*; #(
   parameter int          DATA_W  = 98,
   parameter logic [31:0] PC_RST  = PC_RST_DEF,
   parameter int          SKID_EN = 1,
   parameter int          CNT_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   input  logic [31:0]       in_pc,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [31:0]       out_pc,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);

   localparam int ENT_W = 64 + DATA_W;

   // Entry layout: {instr[31:0], pc[31:0], data[DATA_W-1:0]}
   localparam logic [ENT_W-1:0] ENT_RST = {NOP_INSTR, PC_RST, {DATA_W{1'b0}}};

   state_e           state_q, state_d;
   logic [ENT_W-1:0] head_q, head_d;
   logic [ENT_W-1:0] skid_q, skid_d;
   logic             out_valid_q, out_valid_d;
   logic             in_ready_q, in_ready_d;

   logic             in_xfer;
   logic             out_xfer;
   logic [ENT_W-1:0] in_entry;
   logic             stall_inc;
   logic             bubble_inc;

   assign in_entry = {in_instr, in_pc, in_data};

   // With the skid slot the ready is a flop; without it, a stalled full head
   // must drop ready in the same cycle, so it is derived combinationally.
   always_comb begin
      if (SKID_EN != 0) begin
         in_ready = in_ready_q;
      end else begin
         in_ready = ~out_valid_q | out_ready;
      end
   end

   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid_q & out_ready;

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = ST_EMPTY;
         head_d  = ENT_RST;
         skid_d  = ENT_RST;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (in_xfer) begin
                  state_d = ST_FULL;
                  head_d  = in_entry;
               end
            end
            ST_FULL: begin
               if (in_xfer && out_xfer) begin
                  head_d = in_entry;
               end else if (out_xfer) begin
                  // Drained: keep the last pc, but show a nop head.
                  state_d = ST_EMPTY;
                  head_d  = {NOP_INSTR, head_q[DATA_W +: 32], {DATA_W{1'b0}}};
               end else if (in_xfer) begin
                  // Only reachable with the skid slot enabled.
                  state_d = ST_SKID;
                  skid_d  = in_entry;
               end
            end
            ST_SKID: begin
               if (out_xfer) begin
                  state_d = ST_FULL;
                  head_d  = skid_q;
               end
            end
            default: begin
               state_d = ST_EMPTY;
               head_d  = ENT_RST;
               skid_d  = ENT_RST;
            end
         endcase
      end
      out_valid_d = (state_d != ST_EMPTY);
      in_ready_d  = (state_d != ST_SKID);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_EMPTY;
         head_q      <= ENT_RST;
         skid_q      <= ENT_RST;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         head_q      <= head_d;
         skid_q      <= skid_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_instr = head_q[ENT_W-1 -: 32];
   assign out_pc    = head_q[DATA_W +: 32];
   assign out_data  = head_q[DATA_W-1:0];

   // A flush cycle is neither a stall nor a bubble.
   assign stall_inc  = out_valid_q & ~out_ready & ~flush;
   assign bubble_inc = ~out_valid_q & out_ready & ~flush;

   pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .clear (reset),
      .inc   (stall_inc),
      .cnt   (stall_cnt)
   );

   pipe_sat_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .clear (reset),
      .inc   (bubble_inc),
      .cnt   (bubble_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

   localparam int DW = 98;

   logic          clk = 1'b0;
   logic          reset, flush, in_valid, out_ready;
   logic [31:0]   in_instr, in_pc;
   logic [DW-1:0] in_data;

   // Instance A: defaults (skid slot, 16-bit counters)
   logic          in_ready_a, out_valid_a;
   logic [31:0]   out_instr_a, out_pc_a;
   logic [DW-1:0] out_data_a;
   logic [15:0]   stall_a, bubble_a;

   // Instance B: no skid slot, 4-bit counters
   logic          in_ready_b, out_valid_b;
   logic [31:0]   out_instr_b, out_pc_b;
   logic [DW-1:0] out_data_b;
   logic [3:0]    stall_b, bubble_b;

   always #5 clk = ~clk;

   pipe_stage_buf dut_a (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_a),
      .in_instr(in_instr), .in_pc(in_pc), .in_data(in_data),
      .out_valid(out_valid_a), .out_ready(out_ready),
      .out_instr(out_instr_a), .out_pc(out_pc_a), .out_data(out_data_a),
      .stall_cnt(stall_a), .bubble_cnt(bubble_a)
   );

   pipe_stage_buf #(.SKID_EN(0), .CNT_W(4)) dut_b (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_b),
      .in_instr(in_instr), .in_pc(in_pc), .in_data(in_data),
      .out_valid(out_valid_b), .out_ready(out_ready),
      .out_instr(out_instr_b), .out_pc(out_pc_b), .out_data(out_data_b),
      .stall_cnt(stall_b), .bubble_cnt(bubble_b)
   );

   // Reference model: each buffer is a FIFO of bounded capacity.
   typedef struct {
      logic [31:0]   instr;
      logic [31:0]   pc;
      logic [DW-1:0] data;
   } ent_t;

   ent_t        qa[$];
   ent_t        qb[$];
   int unsigned sa, ba, sb, bb;
   bit          pc_rst_a, pc_rst_b;
   bit          in_rst = 1'b1;

   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_dut();
      if (in_rst) return;
      chk("a_out_valid", out_valid_a, qa.size() > 0);
      chk("a_in_ready", in_ready_a, qa.size() < 2);
      if (qa.size() > 0) begin
         chk("a_out_instr", out_instr_a, qa[0].instr);
         chk("a_out_pc", out_pc_a, qa[0].pc);
         chk("a_out_data", out_data_a, qa[0].data);
      end else begin
         chk("a_nop_instr", out_instr_a, 0);
         chk("a_nop_data", out_data_a, 0);
         if (pc_rst_a) chk("a_rst_pc", out_pc_a, 32'h3000);
      end
      chk("a_stall_cnt", stall_a, sa);
      chk("a_bubble_cnt", bubble_a, ba);

      chk("b_out_valid", out_valid_b, qb.size() > 0);
      chk("b_in_ready", in_ready_b, (qb.size() == 0) || out_ready);
      if (qb.size() > 0) begin
         chk("b_out_instr", out_instr_b, qb[0].instr);
         chk("b_out_pc", out_pc_b, qb[0].pc);
         chk("b_out_data", out_data_b, qb[0].data);
      end else begin
         chk("b_nop_instr", out_instr_b, 0);
         chk("b_nop_data", out_data_b, 0);
         if (pc_rst_b) chk("b_rst_pc", out_pc_b, 32'h3000);
      end
      chk("b_stall_cnt", stall_b, sb);
      chk("b_bubble_cnt", bubble_b, bb);
   endtask

   // Inputs are already applied; check, clock once, advance the model.
   task automatic cycle();
      bit   va, vb, ina, inb, oa, ob;
      ent_t e;
      #1;
      check_dut();
      e.instr = in_instr; e.pc = in_pc; e.data = in_data;
      va  = qa.size() > 0;
      vb  = qb.size() > 0;
      ina = in_valid && (qa.size() < 2);
      inb = in_valid && (!vb || out_ready);
      oa  = va && out_ready;
      ob  = vb && out_ready;
      @(posedge clk);
      #1;
      if (reset) begin
         qa.delete(); qb.delete();
         sa = 0; ba = 0; sb = 0; bb = 0;
         pc_rst_a = 1; pc_rst_b = 1;
         in_rst = 0;
      end else if (flush) begin
         qa.delete(); qb.delete();
         pc_rst_a = 1; pc_rst_b = 1;
      end else begin
         if (va && !out_ready && sa < 16'hFFFF) sa++;
         if (!va && out_ready && ba < 16'hFFFF) ba++;
         if (vb && !out_ready && sb < 15) sb++;
         if (!vb && out_ready && bb < 15) bb++;
         if (oa) void'(qa.pop_front());
         if (ob) void'(qb.pop_front());
         if (ina) begin qa.push_back(e); pc_rst_a = 0; end
         if (inb) begin qb.push_back(e); pc_rst_b = 0; end
      end
   endtask

   task automatic set_in(input logic v, input logic [31:0] instr, input logic [31:0] pc);
      in_valid = v;
      in_instr = instr;
      in_pc    = pc;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
      set_in(1'b0, 32'h0, 32'h0);

      // Reset
      cycle(); cycle();
      reset = 1'b0;
      #1;
      chk("rst_out_valid", out_valid_a, 0);
      chk("rst_out_pc", out_pc_a, 32'h3000);
      chk("rst_out_instr", out_instr_a, 0);
      chk("rst_in_ready", in_ready_a, 1);
      chk("rst_stall", stall_a, 0);
      chk("rst_bubble", bubble_a, 0);

      // Streaming
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         set_in(1'b1, 32'h2402_0001 + i, 32'h3000 + 4 * i);
         cycle();
         chk("stream_instr", out_instr_a, 32'h2402_0001 + i);
      end
      set_in(1'b0, 32'h0, 32'h0);
      cycle();

      // Stall into skid, then release
      out_ready = 1'b0;
      set_in(1'b1, 32'h2402_0100, 32'h3000); cycle();
      chk("b_stall_ready_same_cycle", in_ready_b, 0);
      set_in(1'b1, 32'h2402_0104, 32'h3004); cycle();
      set_in(1'b0, 32'h0, 32'h0);
      chk("skid_in_ready", in_ready_a, 0);
      chk("skid_head_pc", out_pc_a, 32'h3000);
      repeat (3) cycle();
      out_ready = 1'b1;
      #1 chk("b_ready_comb_release", in_ready_b, 1);
      cycle();
      chk("release_first_pc", out_pc_a, 32'h3004);
      cycle(); cycle();

      // Flush while in SKID, with a simultaneous push
      out_ready = 1'b0;
      set_in(1'b1, 32'h2402_0200, 32'h3000); cycle();
      set_in(1'b1, 32'h2402_0204, 32'h3004); cycle();
      flush = 1'b1;
      set_in(1'b1, 32'h2402_0208, 32'h3008); cycle();
      flush = 1'b0;
      set_in(1'b0, 32'h0, 32'h0);
      chk("flush_out_valid", out_valid_a, 0);
      chk("flush_out_instr", out_instr_a, 0);
      chk("flush_out_pc", out_pc_a, 32'h3000);
      chk("flush_in_ready", in_ready_a, 1);
      out_ready = 1'b1;
      repeat (3) cycle();

      // Counter saturation on the 4-bit instance
      reset = 1'b1; cycle(); cycle(); reset = 1'b0;
      out_ready = 1'b1;
      repeat (20) cycle();
      chk("sat_bubble_b", bubble_b, 4'hF);
      chk("sat_bubble_a", bubble_a, 16'd20);

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         set_in(($urandom % 4) != 0, $urandom, $urandom);
         out_ready = ($urandom % 3) != 0;
         flush     = ($urandom % 20) == 0;
         cycle();
      end
      flush = 1'b0;
      set_in(1'b0, 32'h0, 32'h0);
      cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
